// File: rtl/h80bus_arb.sv
// h80bus_arb - two-master round-robin arbiter for the h80 bus.
//
// Shares one h80 bus slave between master 0 and master 1. The owner's
// ce_n/addr/cmd/wdata reach the slave; a requesting non-owner is held with
// wait_n=0. Round-robin on ties, with a per-owner burst limit of MAX_BURST
// completed transfers while the other master waits.
//
// Optional feature macro: H80BUS_ARB_LOCK_EN adds m0_lock/m1_lock; while the
// owner's lock is high no switch happens at completions.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   mX_ce_n/addr/cmd/wdata   master request (X = 0,1)
//   mX_rdata, mX_wait_n      master read data and stall
//   mX_lock                  owner lock (H80BUS_ARB_LOCK_EN only)
//   s_ce_n/addr/cmd          slave request
//   s_data_                  bidirectional slave data
//   s_wait_n                 slave stall
//   grant                    one-hot owner, 00 when idle
module h80bus_arb #(
  parameter int BUS_ADDR_WIDTH = 16,
  parameter int BUS_CMD_WIDTH  = 3,
  parameter int BUS_DATA_WIDTH = 16,
  parameter int MAX_BURST      = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      m0_ce_n,
  input  logic [BUS_ADDR_WIDTH-1:0] m0_addr,
  input  logic [BUS_CMD_WIDTH-1:0]  m0_cmd,
  input  logic [BUS_DATA_WIDTH-1:0] m0_wdata,
  output logic [BUS_DATA_WIDTH-1:0] m0_rdata,
  output logic                      m0_wait_n,
  input  logic                      m1_ce_n,
  input  logic [BUS_ADDR_WIDTH-1:0] m1_addr,
  input  logic [BUS_CMD_WIDTH-1:0]  m1_cmd,
  input  logic [BUS_DATA_WIDTH-1:0] m1_wdata,
  output logic [BUS_DATA_WIDTH-1:0] m1_rdata,
  output logic                      m1_wait_n,
`ifdef H80BUS_ARB_LOCK_EN
  input  logic                      m0_lock,
  input  logic                      m1_lock,
`endif
  output logic                      s_ce_n,
  output logic [BUS_ADDR_WIDTH-1:0] s_addr,
  output logic [BUS_CMD_WIDTH-1:0]  s_cmd,
  inout  wire  [BUS_DATA_WIDTH-1:0] s_data_,
  input  logic                      s_wait_n,
  output logic [1:0]                grant
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [8:0] MAXB = 9'(MAX_BURST);

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] burst, burst_nxt;

  logic req0, req1, own0, own1;
  logic req_own, req_oth, lock_own, done;
  logic [8:0] burst_inc;
  logic [BUS_DATA_WIDTH-1:0] s_wdata;
  logic s_oe;

  assign req0 = ~m0_ce_n;
  assign req1 = ~m1_ce_n;
  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);
  assign grant = {own1, own0};

  // slave-side mux; idle drives an inert bus
  always_comb begin
    s_ce_n  = 1'b1;
    s_addr  = '0;
    s_cmd   = '0;
    s_wdata = '0;
    if (own0) begin
      s_ce_n = m0_ce_n; s_addr = m0_addr; s_cmd = m0_cmd; s_wdata = m0_wdata;
    end else if (own1) begin
      s_ce_n = m1_ce_n; s_addr = m1_addr; s_cmd = m1_cmd; s_wdata = m1_wdata;
    end
  end

  // s_ce_n is already 1 when idle, so no separate owner term is needed
  assign s_oe    = ~s_ce_n & ~s_cmd[0];
  assign s_data_ = s_oe ? s_wdata : 'z;

  // non-owner: wait_n mirrors its own ce_n (stalled only if requesting)
  assign m0_wait_n = own0 ? s_wait_n : m0_ce_n;
  assign m1_wait_n = own1 ? s_wait_n : m1_ce_n;
  assign m0_rdata  = own0 ? s_data_ : '0;
  assign m1_rdata  = own1 ? s_data_ : '0;

  assign req_own   = own0 ? req0 : req1;
  assign req_oth   = own0 ? req1 : req0;
  assign done      = ~s_ce_n & s_wait_n;
  assign burst_inc = {1'b0, burst} + 9'd1;

`ifdef H80BUS_ARB_LOCK_EN
  assign lock_own = (own0 & m0_lock) | (own1 & m1_lock);
`else
  assign lock_own = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    burst_nxt = burst;
    case (state)
      IDLE: begin
        // tie goes to the master that did not own last
        if (req0 && (!req1 || last)) begin
          state_nxt = OWN0;
          burst_nxt = '0;
        end else if (req1) begin
          state_nxt = OWN1;
          burst_nxt = '0;
        end
      end
      OWN0, OWN1: begin
        if (!req_own) begin
          // owner released (possibly mid-transfer): hand over or go idle
          state_nxt = req_oth ? (own0 ? OWN1 : OWN0) : IDLE;
          last_nxt  = own1;
          burst_nxt = '0;
        end else if (req_oth && done) begin
          if (lock_own)
            burst_nxt = (burst_inc >= MAXB) ? MAXB[7:0] : burst_inc[7:0];
          else if (burst_inc >= MAXB) begin
            // >= because a saturated locked burst may already sit at MAX
            state_nxt = own0 ? OWN1 : OWN0;
            last_nxt  = own1;
            burst_nxt = '0;
          end else
            burst_nxt = burst_inc[7:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
      burst <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      burst <= burst_nxt;
    end
  end

endmodule

// File: tb/tb_h80bus_arb.sv
// Directed bench for h80bus_arb with a small memory slave model.
// Expected values go into a scoreboard queue as stimulus is applied and are
// popped in order when the DUT outputs are sampled on the falling edge.
module tb_h80bus_arb;

  logic        clk, reset_n;
  logic        m0_ce_n, m1_ce_n;
  logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [2:0]  m0_cmd, m1_cmd;
  logic        m0_wait_n, m1_wait_n;
  logic        m0_lock, m1_lock;
  logic        s_ce_n, s_wait_n;
  logic [15:0] s_addr;
  logic [2:0]  s_cmd;
  wire  [15:0] s_data_;
  logic [1:0]  grant;

  h80bus_arb dut (
    .clk(clk), .reset_n(reset_n),
    .m0_ce_n(m0_ce_n), .m0_addr(m0_addr), .m0_cmd(m0_cmd), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_wait_n(m0_wait_n),
    .m1_ce_n(m1_ce_n), .m1_addr(m1_addr), .m1_cmd(m1_cmd), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_wait_n(m1_wait_n),
`ifdef H80BUS_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .s_ce_n(s_ce_n), .s_addr(s_addr), .s_cmd(s_cmd), .s_data_(s_data_),
    .s_wait_n(s_wait_n), .grant(grant)
  );

  // memory slave: writes at completion, combinational read drive
  logic [15:0] mem [256];
  always @(posedge clk)
    if (!s_ce_n && s_wait_n && !s_cmd[0]) mem[s_addr[7:0]] <= s_data_;
  assign s_data_ = (!s_ce_n && s_cmd[0]) ? mem[s_addr[7:0]] : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;

  task automatic push(input string t, input logic [31:0] v);
    q.push_back('{t, v});
  endtask

  task automatic ck(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0h with no expectation", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) begin n_pass++; end
      else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; s_wait_n = 1'b1;
    m0_ce_n = 1'b1; m0_addr = '0; m0_cmd = '0; m0_wdata = '0;
    m1_ce_n = 1'b1; m1_addr = '0; m1_cmd = '0; m1_wdata = '0;
    m0_lock = 1'b0; m1_lock = 1'b0;

    // reset values, both idle
    push("rst_grant", 0); push("rst_s_ce_n", 1); push("rst_s_addr", 0);
    push("rst_s_cmd", 0); push("rst_s_oe", 0); push("rst_m0_wait_n", 1);
    push("rst_m1_wait_n", 1); push("rst_m0_rdata", 0);
    @(negedge clk);
    ck(grant); ck(s_ce_n); ck(s_addr); ck(s_cmd); ck(dut.s_oe);
    ck(m0_wait_n); ck(m1_wait_n); ck(m0_rdata);
    m0_ce_n = 1'b0; #1;
    push("rst_req_m0_wait_n", 0); push("rst_req_m0_rdata", 0);
    ck(m0_wait_n); ck(m0_rdata);
    m0_ce_n = 1'b1;
    tick(); reset_n = 1'b1;

    // m0 writes A55A to 0010, then reads it back with no bubble
    tick();
    m0_ce_n = 1'b0; m0_addr = 16'h0010; m0_cmd = 3'b000; m0_wdata = 16'hA55A;
    tick();
    push("wr_grant", 1); push("wr_s_ce_n", 0); push("wr_s_addr", 16'h0010);
    push("wr_s_data", 16'hA55A); push("wr_m0_wait_n", 1); push("wr_m1_wait_n", 1);
    @(negedge clk);
    ck(grant); ck(s_ce_n); ck(s_addr); ck(s_data_); ck(m0_wait_n); ck(m1_wait_n);
    tick();
    m0_cmd = 3'b001;
    push("rd_grant", 1); push("rd_s_oe", 0); push("rd_m0_rdata", 16'hA55A);
    push("rd_m1_wait_n", 1);
    @(negedge clk);
    ck(grant); ck(dut.s_oe); ck(m0_rdata); ck(m1_wait_n);
    tick();
    m0_ce_n = 1'b1; m0_cmd = 3'b000;
    tick();
    push("rel_grant", 0); push("rel_m1_wait_n", 1);
    @(negedge clk);
    ck(grant); ck(m1_wait_n);

    // reset, then tie: m0 first, switch to m1 after 4 m0 completions
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    tick();
    m0_ce_n = 1'b0; m0_addr = 16'h0020; m0_wdata = 16'h1000;
    m1_ce_n = 1'b0; m1_addr = 16'h0030; m1_wdata = 16'h2000; m1_cmd = 3'b000;
    s_wait_n = 1'b0;
    tick();
    push("tie_grant", 1); push("tie_m0_wait_n", 0); push("tie_m1_wait_n", 0);
    push("tie_m1_rdata", 0);
    @(negedge clk);
    ck(grant); ck(m0_wait_n); ck(m1_wait_n); ck(m1_rdata);
    s_wait_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("burst_grant", 1); push("burst_s_addr", 16'h0020 + 16'(i));
      ck(grant); ck(s_addr);
      tick();
      m0_addr = 16'h0021 + 16'(i); m0_wdata = 16'h1001 + 16'(i);
      @(negedge clk);
    end
    push("sw_grant", 2); push("sw_m0_wait_n", 0); push("sw_m1_wait_n", 1);
    push("sw_s_addr", 16'h0030); push("sw_s_data", 16'h2000); push("sw_m0_rdata", 0);
    ck(grant); ck(m0_wait_n); ck(m1_wait_n); ck(s_addr); ck(s_data_); ck(m0_rdata);

    // m1 drops its request mid-transfer while m0 waits: immediate handover
    s_wait_n = 1'b0;
    tick();
    m1_ce_n = 1'b1;
    push("drop_grant_hold", 2); push("drop_s_ce_n", 1);
    @(negedge clk);
    ck(grant); ck(s_ce_n);
    tick();
    push("drop_grant", 1); push("drop_m0_wait_n", 0); push("drop_m1_wait_n", 1);
    @(negedge clk);
    ck(grant); ck(m0_wait_n); ck(m1_wait_n);
    s_wait_n = 1'b1;
    tick();
    m0_ce_n = 1'b1;
    tick();
    push("idle_grant", 0); push("mem_20", 16'h1000); push("mem_23", 16'h1003);
    push("mem_24", 16'h1004);
    @(negedge clk);
    ck(grant); ck(mem[8'h20]); ck(mem[8'h23]); ck(mem[8'h24]);

    // async reset while m1 is mid-write
    tick();
    m1_ce_n = 1'b0; m1_addr = 16'h0040; m1_wdata = 16'hBEEF; s_wait_n = 1'b0;
    tick();
    push("mid_grant", 2); push("mid_s_ce_n", 0); push("mid_s_data", 16'hBEEF);
    @(negedge clk);
    ck(grant); ck(s_ce_n); ck(s_data_);
    #1 reset_n = 1'b0;
    #1;
    push("arst_s_ce_n", 1); push("arst_s_oe", 0); push("arst_grant", 0);
    push("arst_m1_wait_n", 0);
    ck(s_ce_n); ck(dut.s_oe); ck(grant); ck(m1_wait_n);
    m0_ce_n = 1'b0; m0_addr = 16'h0050; m0_wdata = 16'h3000;
    tick(); reset_n = 1'b1; s_wait_n = 1'b1;
    tick();
    push("post_rst_tie", 1);
    @(negedge clk);
    ck(grant);

`ifdef H80BUS_ARB_LOCK_EN
    // lock holds m0 through 6 completions; m1 after unlock + next completion
    m0_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push("lock_grant", 1);
      ck(grant);
      tick();
      m0_addr = 16'h0051 + 16'(i);
      if (i == 5) m0_lock = 1'b0;
      @(negedge clk);
    end
    push("unlock_grant_hold", 1);
    ck(grant);
    tick();
    push("unlock_grant", 2);
    @(negedge clk);
    ck(grant);
`endif

    m0_ce_n = 1'b1; m1_ce_n = 1'b1;
    tick(); tick();
    push("end_grant", 0);
    @(negedge clk);
    ck(grant);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
